// File: rtl/apb_to_ahbl_if.sv
// APB and AHB-Lite bus bundles used by the APB-to-AHB-Lite bridge.
// Latency: none (pure signal grouping).
// Backpressure: apb pready stretches the APB access phase; ahbl hready stalls AHB phases.
// Ports: apb_if carries psel/penable/pwrite/paddr/pwdata out of the master and
//        prdata/pready/pslverr back; ahbl_if carries haddr/hwrite/htrans/hsize/
//        hburst/hprot/hmastlock/hwdata out of the master and hready/hresp/hrdata back.

interface apb_if #(
  parameter int W_ADDR = 16,
  parameter int W_DATA = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [W_ADDR-1:0] paddr;
  logic [W_DATA-1:0] pwdata;
  logic [W_DATA-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

interface ahbl_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [W_DATA-1:0] hrdata;

  modport master (
    output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/apb_to_ahbl.sv
// APB completer turning each APB transfer into one AHB-Lite single NONSEQ word transfer.
// Latency: 4 cycles setup-to-pready with zero AHB waits; +1 per AHB wait state, +1 for an error.
// Backpressure: pready is held low until the AHB data phase completes (hready stalls both phases).
// Ports: clk, rst (synchronous, active-high); apbs = APB completer side (apb_if.slave);
//        ahblm = AHB-Lite manager side (ahbl_if.master).
// Build option: define APB_TO_AHBL_PSLVERR_EN to report AHB errors on pslverr;
//        otherwise pslverr is tied low and errored transfers complete as successes.

module apb_to_ahbl #(
  parameter int                   W_PADDR    = 16,
  parameter int                   W_HADDR    = 32,
  parameter int                   W_DATA     = 32,
  parameter logic [W_HADDR-1:0]   HADDR_BASE = '0
) (
  input  logic   clk,
  input  logic   rst,
  apb_if.slave   apbs,
  ahbl_if.master ahblm
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_APH  = 2'd1,
    S_DPH  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [W_PADDR-1:0]  addr_q;
  logic                write_q;
  logic [W_DATA-1:0]   wdata_q;
  logic [W_DATA-1:0]   rdata_q;
  logic [1:0]          htrans_q;
  logic                capture;
  logic                complete;
  logic                load_rdata;

  // Next state. Setup phases outside S_IDLE are ignored, and a dropped psel
  // does not abort: the AHB transfer and the pready pulse always run out.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (apbs.psel && !apbs.penable) begin
          capture = 1'b1;
          state_d = S_APH;
        end
      end
      S_APH: begin
        if (ahblm.hready) state_d = S_DPH;
      end
      S_DPH: begin
        if (ahblm.hready) begin
          complete = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef APB_TO_AHBL_PSLVERR_EN
  logic err_q;
  // An errored read must not disturb the last good read data.
  assign load_rdata = complete && !write_q && !ahblm.hresp;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (complete) begin
      err_q <= ahblm.hresp;
    end
  end

  assign apbs.pslverr = (state_q == S_RESP) && err_q;
`else
  logic unused_hresp;
  // Errors are invisible here, so every completed read is treated as good.
  assign load_rdata   = complete && !write_q;
  assign unused_hresp = ahblm.hresp;
  assign apbs.pslverr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      htrans_q <= HTRANS_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      // NONSEQ exactly while the address phase is open (held through hready stalls).
      htrans_q <= (state_d == S_APH) ? HTRANS_NONSEQ : HTRANS_IDLE;
      if (capture) begin
        addr_q  <= apbs.paddr;
        write_q <= apbs.pwrite;
        wdata_q <= apbs.pwdata;
      end
      if (load_rdata) begin
        rdata_q <= ahblm.hrdata;
      end
    end
  end

  assign ahblm.haddr     = HADDR_BASE | W_HADDR'(addr_q);
  assign ahblm.hwrite    = write_q;
  assign ahblm.htrans    = htrans_q;
  assign ahblm.hsize     = 3'b010;
  assign ahblm.hburst    = 3'b000;
  assign ahblm.hprot     = 4'b0011;
  assign ahblm.hmastlock = 1'b0;
  assign ahblm.hwdata    = wdata_q;

  assign apbs.prdata = rdata_q;
  assign apbs.pready = (state_q == S_RESP);

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Bench for apb_to_ahbl: APB master and AHB-Lite responder driven from one initial block.
// Latency: n/a.
// Backpressure: the responder inserts address/data wait states and two-cycle error responses.

module tb_apb_to_ahbl;

  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef APB_TO_AHBL_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_if  #(.W_ADDR(16), .W_DATA(32)) apbs ();
  ahbl_if #(.W_ADDR(32), .W_DATA(32)) ahblm ();

  apb_to_ahbl #(
    .W_PADDR   (16),
    .W_HADDR   (32),
    .W_DATA    (32),
    .HADDR_BASE(BASE)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .apbs (apbs),
    .ahblm(ahblm)
  );

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_prdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle APB cycles: nothing may move on either bus.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      apbs.psel    = 1'b0;
      apbs.penable = 1'b0;
      check("idle_pready", apbs.pready, 32'd0);
      check("idle_htrans", ahblm.htrans, 32'd0);
    end
  endtask

  // One APB transfer, with the AHB responder inserting aw address-phase waits,
  // dw data-phase waits and optionally a two-cycle error response.
  // Expected completion: access cycle 3 + aw + dw + er after the setup cycle.
  task automatic xfer(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                      input int aw, input int dw, input bit er, input logic [31:0] rd);
    int          cyc;
    int          ns;
    int          aw_left;
    int          dw_left;
    bit          in_dph;
    bit          err_first;
    bit          done;
    bit          wd_checked;
    logic [31:0] exp_haddr;
    exp_haddr  = BASE | {16'h0, a};
    cyc        = 0;
    ns         = 0;
    aw_left    = aw;
    dw_left    = dw;
    in_dph     = 1'b0;
    err_first  = 1'b0;
    done       = 1'b0;
    wd_checked = 1'b0;

    @(negedge clk);
    check("setup_pready", apbs.pready, 32'd0);
    check("setup_htrans", ahblm.htrans, 32'd0);
    apbs.psel     = 1'b1;
    apbs.penable  = 1'b0;
    apbs.pwrite   = wr;
    apbs.paddr    = a;
    apbs.pwdata   = wd;
    ahblm.hready  = 1'b1;
    ahblm.hresp   = 1'b0;
    ahblm.hrdata  = $urandom;

    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      apbs.penable = 1'b1;
      if (ahblm.htrans == 2'b10) begin
        ns++;
        check("aph_haddr", ahblm.haddr, exp_haddr);
        check("aph_hwrite", ahblm.hwrite, 32'(wr));
      end
      if (apbs.pready === 1'b1) begin
        done = 1'b1;
        check("latency", cyc, 32'(3 + aw + dw + int'(er)));
        check("pslverr", apbs.pslverr, 32'(ERR_EN && er));
        if (!wr && !(ERR_EN && er)) exp_prdata = rd;
        check("prdata", apbs.prdata, exp_prdata);
        check("nonseq_cycles", ns, 32'(1 + aw));
      end else begin
        check("pslverr_low", apbs.pslverr, 32'd0);
        ahblm.hrdata = $urandom;
        ahblm.hresp  = 1'b0;
        ahblm.hready = 1'b1;
        if (ahblm.htrans == 2'b10) begin
          if (aw_left > 0) begin
            ahblm.hready = 1'b0;
            aw_left--;
          end else begin
            in_dph = 1'b1;
          end
        end else if (in_dph) begin
          if (wr && !wd_checked) begin
            check("dph_hwdata", ahblm.hwdata, wd);
            wd_checked = 1'b1;
          end
          if (dw_left > 0) begin
            ahblm.hready = 1'b0;
            dw_left--;
          end else if (er && !err_first) begin
            ahblm.hready = 1'b0;
            ahblm.hresp  = 1'b1;
            err_first    = 1'b1;
          end else begin
            ahblm.hresp  = er;
            ahblm.hrdata = rd;
            in_dph       = 1'b0;
          end
        end
      end
    end
    if (!done) check("pready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    apbs.psel     = 1'b0;
    apbs.penable  = 1'b0;
    apbs.pwrite   = 1'b0;
    apbs.paddr    = '0;
    apbs.pwdata   = '0;
    ahblm.hready  = 1'b1;
    ahblm.hresp   = 1'b0;
    ahblm.hrdata  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and constant AHB attributes.
    check("rst_htrans", ahblm.htrans, 32'd0);
    check("rst_pready", apbs.pready, 32'd0);
    check("rst_pslverr", apbs.pslverr, 32'd0);
    check("rst_prdata", apbs.prdata, 32'd0);
    check("rst_haddr", ahblm.haddr, BASE);
    check("rst_hwrite", ahblm.hwrite, 32'd0);
    check("rst_hwdata", ahblm.hwdata, 32'd0);
    check("hsize", ahblm.hsize, 32'd2);
    check("hburst", ahblm.hburst, 32'd0);
    check("hprot", ahblm.hprot, 32'd3);
    check("hmastlock", ahblm.hmastlock, 32'd0);

    // Directed cases.
    xfer(1'b1, 16'h0010, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0);
    idle(1);
    xfer(1'b0, 16'h0020, 32'h0, 0, 2, 1'b0, 32'h1234_5678);
    idle(1);
    xfer(1'b1, 16'h0030, 32'hCAFE_F00D, 3, 0, 1'b0, 32'h0);
    xfer(1'b0, 16'h0040, 32'h0, 0, 0, 1'b1, 32'hBAD0_BAD0);
    xfer(1'b1, 16'h0044, 32'h0BAD_F00D, 0, 0, 1'b0, 32'h0);
    xfer(1'b0, 16'hFFFC, 32'h0, 0, 0, 1'b0, 32'h5A5A_A5A5);
    idle(2);

    // Randomized transfers with random gaps.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      ra = 16'($urandom) & 16'hFFFC;
      xfer(1'($urandom), ra, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
           ($urandom_range(0, 4) == 0), $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    // Make prdata non-zero, then reset in the middle of a data phase.
    xfer(1'b0, 16'h0050, 32'h0, 0, 0, 1'b0, 32'h7777_1111);
    @(negedge clk);
    apbs.psel     = 1'b1;
    apbs.penable  = 1'b0;
    apbs.pwrite   = 1'b1;
    apbs.paddr    = 16'h0100;
    apbs.pwdata   = 32'h1111_2222;
    ahblm.hready  = 1'b1;
    @(negedge clk);
    apbs.penable = 1'b1;
    check("rstmid_nonseq", ahblm.htrans, 32'd2);
    @(negedge clk);
    ahblm.hready = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    check("rstmid_htrans", ahblm.htrans, 32'd0);
    check("rstmid_pready", apbs.pready, 32'd0);
    check("rstmid_pslverr", apbs.pslverr, 32'd0);
    check("rstmid_prdata", apbs.prdata, 32'd0);
    check("rstmid_haddr", ahblm.haddr, BASE);
    check("rstmid_hwrite", ahblm.hwrite, 32'd0);
    rst          = 1'b0;
    apbs.psel    = 1'b0;
    apbs.penable = 1'b0;
    ahblm.hready = 1'b1;
    exp_prdata   = 32'h0;
    idle(2);
    xfer(1'b0, 16'h0060, 32'h0, 1, 1, 1'b0, 32'h2468_ACE0);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
